mc_port_mux: RTL and testbench
==============================

# mc_port_mux

Multiplexes NUM_CORES independent phold cores onto one Convey MC port. It sits directly downstream of the phold cores' memory interfaces and upstream of the MC port pins of cae_pers. Requests are arbitrated round-robin and registered, and each core's index is tagged into the rtnctl top bits. Responses are steered back to the owning core by that tag. Write-flush requests are collected from all cores and issued to the MC as a single flush sequence.

## Interface
Parameters:
- NUM_CORES, 4: cores sharing the port; power of two, 2..16.
- RTNCTL_WIDTH, 32: MC rtnctl width.
- CORE_BITS, $clog2(NUM_CORES): tag width, placed in rtnctl[RTNCTL_WIDTH-1 -: CORE_BITS].

Ports (core buses flattened, core i at slice i):
- clk  in  1  personality clock.
- i_reset  in  1  synchronous, active-high reset.
- core_rq_vld  in  NUM_CORES  request valid per core.
- core_rq_rdy  out  NUM_CORES  request accepted this cycle (one-hot or zero).
- core_rq_cmd / core_rq_scmd / core_rq_size  in  3 / 4 / 2 ×NUM_CORES  MC command fields.
- core_rq_vadr / core_rq_data  in  48 / 64 ×NUM_CORES  address, write data.
- core_rq_rtnctl  in  (RTNCTL_WIDTH-CORE_BITS)×NUM_CORES  core-private tag.
- core_rq_flush  in  NUM_CORES  one-cycle flush request pulse.
- core_flush_cmplt  out  NUM_CORES  flush-complete pulse.
- core_rs_vld  out  NUM_CORES  response valid, one-hot.
- core_rs_cmd / core_rs_scmd / core_rs_data / core_rs_rtnctl  out  3/4/64/(RTNCTL_WIDTH-CORE_BITS)  shared response bus.
- core_rs_stall  in  NUM_CORES  per-core response backpressure.
- mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl  out  1/3/4/2/48/64/RTNCTL_WIDTH  MC request.
- mc_rq_stall  in  1  MC backpressure.
- mc_rq_flush  out  1  flush request pulse.
- mc_rs_flush_cmplt  in  1  flush-complete pulse.
- mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl  in  1/3/4/64/RTNCTL_WIDTH  MC response.
- mc_rs_stall  out  1  response backpressure.
- stat_rq_cnt, stat_stall_cnt  out  32 each  statistics counters.

## Operation
- Arbitration: round-robin pointer starts at core 0. Each cycle, if mc_rq_stall is low, flush state is not FL_ISSUE, and some core_rq_vld is high, grant the first requesting core at or after the pointer.
- On a grant, assert core_rq_rdy[g] combinationally and advance the pointer to g+1 mod NUM_CORES. If mc_rq_stall is high, no core receives rdy.
- Request register: the granted fields are loaded into the output register. mc_rq_rtnctl = {g[CORE_BITS-1:0], core tag}, and mc_rq_vld=1 for exactly one cycle per grant.
- Response steering: when mc_rs_vld is high, core id = mc_rs_rtnctl top CORE_BITS. The response is registered: next cycle core_rs_vld[id]=1, the shared bus carries cmd/scmd/data, and the low rtnctl bits are returned with the tag stripped.
- Response backpressure: mc_rs_stall is the registered OR of core_rs_stall. The MC may still deliver up to 2 responses after stall asserts, and cores absorb them.
- Flush FSM:
  - FL_IDLE: core_rq_flush pulses OR into pend_mask; when pend_mask≠0, go to FL_ISSUE.
  - FL_ISSUE: grants are blocked for one cycle, then mc_rq_flush=1 for one cycle; latch pend_mask into wait_mask, clear pend_mask, go to FL_WAIT.
  - FL_WAIT: new flush pulses go into pend_mask. On mc_rs_flush_cmplt, pulse core_flush_cmplt=wait_mask, clear wait_mask, go to FL_IDLE.
- Simultaneous events: a flush pulse arriving in the same cycle as the FL_ISSUE transition joins the current flush. A pulse arriving during FL_WAIT is served by the next flush.
- Reset: clears all state immediately. Outputs reset to zero; the pointer resets to 0 and flush state to FL_IDLE. Outstanding MC responses arriving after reset are still steered and are not dropped.

## Timing
- Request latency: core accept at cycle t, mc_rq_vld at t+1. Throughput is 1 request/cycle.
- Response latency: mc_rs_vld at t, core_rs_vld at t+1.
- mc_rs_stall lags core_rs_stall by 1 cycle.
- Flush: mc_rq_flush rises 2 cycles after the first pending pulse. core_flush_cmplt rises 1 cycle after mc_rs_flush_cmplt.

## Configuration
- MC_PORT_MUX_STATS_EN defined:
  - stat_rq_cnt counts mc_rq_vld cycles.
  - stat_stall_cnt counts cycles with mc_rq_stall high and any core_rq_vld high.
  - Both counters are 32-bit, saturate at 32'hFFFFFFFF, and are cleared by i_reset.
- Undefined: both counter outputs are tied to 0 and no counter logic is generated.

## Structure
- Shared package mc_port_pkg: MC field widths (cmd 3, scmd 4, size 2, vadr 48, data 64) and flush-state encoding FL_IDLE=0, FL_ISSUE=1, FL_WAIT=2.
- Sub-module rr_arb, parameterised by N: inputs req and en, outputs a one-hot gnt; it holds the round-robin pointer.

## Test plan
- Cores 0 and 2 both hold vld with no stall → grants alternate 0,2,0,2. mc_rq_rtnctl top 2 bits carry 0,2, and mc_rq_vld is high every cycle.
- mc_rq_stall held high for 5 cycles with core 1 valid → core_rq_rdy=0 and mc_rq_vld=0 for those cycles. Core 1 is granted in the first cycle stall is low, and mc_rq_vld is seen the next cycle.
- Response with rtnctl=32'hC000_0123 (NUM_CORES=4) → one cycle later core_rs_vld=4'b1000, core_rs_rtnctl=30'h123.
- core_rs_stall[1]=1 at t → mc_rs_stall=1 at t+1. Two responses still in flight are delivered intact.
- core_rq_flush pulses on cores 0 and 3 in the same cycle → one mc_rq_flush two cycles later. A pulse from core 1 during FL_WAIT is deferred. mc_rs_flush_cmplt → core_flush_cmplt=4'b1001, then a second flush is issued for core 1.
- i_reset asserted mid-flush in FL_WAIT → all outputs return to 0. Pointer and masks are cleared, no core_flush_cmplt is generated, and with MC_PORT_MUX_STATS_EN the counters read 0.

Source files
------------

// File: rtl/mc_port_pkg.sv
// mc_port_pkg: MC field widths and flush FSM encoding
// shared by the mc_port_mux slice.
package mc_port_pkg;

  localparam int CMD_W  = 3;
  localparam int SCMD_W = 4;
  localparam int SIZE_W = 2;
  localparam int VADR_W = 48;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_ISSUE = 2'd1,
    FL_WAIT  = 2'd2
  } fl_state_t;

endpackage

// File: rtl/mc_port_mux_if.sv
// mc_port_mux_if: flattened core buses plus the MC port pins.
// master is the mux view, slave is the cores/MC side.
interface mc_port_mux_if
  import mc_port_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int CORE_BITS    = $clog2(NUM_CORES)
);

  localparam int TW = RTNCTL_WIDTH - CORE_BITS;

  logic [NUM_CORES-1:0]        core_rq_vld;
  logic [NUM_CORES-1:0]        core_rq_rdy;
  logic [NUM_CORES*CMD_W-1:0]  core_rq_cmd;
  logic [NUM_CORES*SCMD_W-1:0] core_rq_scmd;
  logic [NUM_CORES*SIZE_W-1:0] core_rq_size;
  logic [NUM_CORES*VADR_W-1:0] core_rq_vadr;
  logic [NUM_CORES*DATA_W-1:0] core_rq_data;
  logic [NUM_CORES*TW-1:0]     core_rq_rtnctl;
  logic [NUM_CORES-1:0]        core_rq_flush;
  logic [NUM_CORES-1:0]        core_flush_cmplt;
  logic [NUM_CORES-1:0]        core_rs_vld;
  logic [CMD_W-1:0]            core_rs_cmd;
  logic [SCMD_W-1:0]           core_rs_scmd;
  logic [DATA_W-1:0]           core_rs_data;
  logic [TW-1:0]               core_rs_rtnctl;
  logic [NUM_CORES-1:0]        core_rs_stall;

  logic                        mc_rq_vld;
  logic [CMD_W-1:0]            mc_rq_cmd;
  logic [SCMD_W-1:0]           mc_rq_scmd;
  logic [SIZE_W-1:0]           mc_rq_size;
  logic [VADR_W-1:0]           mc_rq_vadr;
  logic [DATA_W-1:0]           mc_rq_data;
  logic [RTNCTL_WIDTH-1:0]     mc_rq_rtnctl;
  logic                        mc_rq_stall;
  logic                        mc_rq_flush;
  logic                        mc_rs_flush_cmplt;
  logic                        mc_rs_vld;
  logic [CMD_W-1:0]            mc_rs_cmd;
  logic [SCMD_W-1:0]           mc_rs_scmd;
  logic [DATA_W-1:0]           mc_rs_data;
  logic [RTNCTL_WIDTH-1:0]     mc_rs_rtnctl;
  logic                        mc_rs_stall;

  modport master (
    input  core_rq_vld, core_rq_cmd, core_rq_scmd,
    input  core_rq_size, core_rq_vadr, core_rq_data,
    input  core_rq_rtnctl, core_rq_flush, core_rs_stall,
    input  mc_rq_stall, mc_rs_flush_cmplt, mc_rs_vld,
    input  mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    output core_rq_rdy, core_flush_cmplt, core_rs_vld,
    output core_rs_cmd, core_rs_scmd, core_rs_data,
    output core_rs_rtnctl, mc_rq_vld, mc_rq_cmd,
    output mc_rq_scmd, mc_rq_size, mc_rq_vadr,
    output mc_rq_data, mc_rq_rtnctl, mc_rq_flush,
    output mc_rs_stall
  );

  modport slave (
    output core_rq_vld, core_rq_cmd, core_rq_scmd,
    output core_rq_size, core_rq_vadr, core_rq_data,
    output core_rq_rtnctl, core_rq_flush, core_rs_stall,
    output mc_rq_stall, mc_rs_flush_cmplt, mc_rs_vld,
    output mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    input  core_rq_rdy, core_flush_cmplt, core_rs_vld,
    input  core_rs_cmd, core_rs_scmd, core_rs_data,
    input  core_rs_rtnctl, mc_rq_vld, mc_rq_cmd,
    input  mc_rq_scmd, mc_rq_size, mc_rq_vadr,
    input  mc_rq_data, mc_rq_rtnctl, mc_rq_flush,
    input  mc_rs_stall
  );

endinterface

// File: rtl/mc_port_mux_rr_arb.sv
// rr_arb: round-robin one-hot grant over N requesters,
// pointer moves past the winner on every grant.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] gidx;
  logic          found;

  // N is a power of two, so pointer arithmetic wraps for free
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + PW'(k);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gidx     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= gidx + PW'(1);
    end
  end

endmodule

// File: rtl/mc_port_mux.sv
// mc_port_mux: N phold cores onto one Convey MC port with tag
// steering and merged flushes; MC_PORT_MUX_STATS_EN adds counters.
module mc_port_mux
  import mc_port_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int CORE_BITS    = $clog2(NUM_CORES)
) (
  input  logic         clk,
  input  logic         i_reset,
  mc_port_mux_if.master bus,
  output logic [31:0]  stat_rq_cnt,
  output logic [31:0]  stat_stall_cnt
);

  localparam int TW = RTNCTL_WIDTH - CORE_BITS;

  fl_state_t            fl_state;
  logic [NUM_CORES-1:0] pend_mask;
  logic [NUM_CORES-1:0] wait_mask;
  logic [NUM_CORES-1:0] gnt;
  logic [CORE_BITS-1:0] g;
  logic                 arb_en;
  logic [CORE_BITS-1:0] rs_id;
  logic [NUM_CORES-1:0] fl_any;

  assign arb_en = !bus.mc_rq_stall && (fl_state != FL_ISSUE);

  rr_arb #(
    .N(NUM_CORES)
  ) u_arb (
    .clk(clk),
    .rst(i_reset),
    .req(bus.core_rq_vld),
    .en (arb_en),
    .gnt(gnt)
  );

  assign bus.core_rq_rdy = gnt;

  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) g = CORE_BITS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      bus.mc_rq_vld    <= 1'b0;
      bus.mc_rq_cmd    <= '0;
      bus.mc_rq_scmd   <= '0;
      bus.mc_rq_size   <= '0;
      bus.mc_rq_vadr   <= '0;
      bus.mc_rq_data   <= '0;
      bus.mc_rq_rtnctl <= '0;
    end else begin
      bus.mc_rq_vld <= |gnt;
      if (|gnt) begin
        bus.mc_rq_cmd  <=
          bus.core_rq_cmd[int'(g)*CMD_W +: CMD_W];
        bus.mc_rq_scmd <=
          bus.core_rq_scmd[int'(g)*SCMD_W +: SCMD_W];
        bus.mc_rq_size <=
          bus.core_rq_size[int'(g)*SIZE_W +: SIZE_W];
        bus.mc_rq_vadr <=
          bus.core_rq_vadr[int'(g)*VADR_W +: VADR_W];
        bus.mc_rq_data <=
          bus.core_rq_data[int'(g)*DATA_W +: DATA_W];
        bus.mc_rq_rtnctl <=
          {g, bus.core_rq_rtnctl[int'(g)*TW +: TW]};
      end
    end
  end

  assign rs_id = bus.mc_rs_rtnctl[RTNCTL_WIDTH-1 -: CORE_BITS];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      bus.core_rs_vld    <= '0;
      bus.core_rs_cmd    <= '0;
      bus.core_rs_scmd   <= '0;
      bus.core_rs_data   <= '0;
      bus.core_rs_rtnctl <= '0;
      bus.mc_rs_stall    <= 1'b0;
    end else begin
      bus.core_rs_vld <= '0;
      if (bus.mc_rs_vld) begin
        bus.core_rs_vld    <= NUM_CORES'(1) << rs_id;
        bus.core_rs_cmd    <= bus.mc_rs_cmd;
        bus.core_rs_scmd   <= bus.mc_rs_scmd;
        bus.core_rs_data   <= bus.mc_rs_data;
        bus.core_rs_rtnctl <= bus.mc_rs_rtnctl[TW-1:0];
      end
      bus.mc_rs_stall <= |bus.core_rs_stall;
    end
  end

  // pulses seen while entering or sitting in ISSUE join this flush
  assign fl_any = pend_mask | bus.core_rq_flush;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      fl_state             <= FL_IDLE;
      pend_mask            <= '0;
      wait_mask            <= '0;
      bus.mc_rq_flush      <= 1'b0;
      bus.core_flush_cmplt <= '0;
    end else begin
      bus.mc_rq_flush      <= 1'b0;
      bus.core_flush_cmplt <= '0;
      unique case (fl_state)
        FL_IDLE: begin
          pend_mask <= fl_any;
          if (fl_any != '0) fl_state <= FL_ISSUE;
        end
        FL_ISSUE: begin
          bus.mc_rq_flush <= 1'b1;
          wait_mask       <= fl_any;
          pend_mask       <= '0;
          fl_state        <= FL_WAIT;
        end
        FL_WAIT: begin
          pend_mask <= fl_any;
          if (bus.mc_rs_flush_cmplt) begin
            bus.core_flush_cmplt <= wait_mask;
            wait_mask            <= '0;
            fl_state             <= FL_IDLE;
          end
        end
        default: fl_state <= FL_IDLE;
      endcase
    end
  end

`ifdef MC_PORT_MUX_STATS_EN
  always_ff @(posedge clk) begin
    if (i_reset) begin
      stat_rq_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (bus.mc_rq_vld && stat_rq_cnt != '1) begin
        stat_rq_cnt <= stat_rq_cnt + 32'd1;
      end
      if (bus.mc_rq_stall && (|bus.core_rq_vld) &&
          stat_stall_cnt != '1) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`else
  assign stat_rq_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_port_mux.sv
// tb_mc_port_mux: directed stimulus with queued expectations
// popped by a negedge monitor.
module tb_mc_port_mux;

  localparam int NC = 4;
  localparam int RW = 32;

  typedef struct {
    int          cyc;
    logic [40:0] hdr;
    logic [47:0] vadr;
    logic [63:0] data;
  } rq_t;

  typedef struct {
    int          cyc;
    logic [3:0]  mask;
    logic [29:0] rtn;
    logic [63:0] data;
    logic [6:0]  cs;
  } rs_t;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } cm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stat_rq_cnt;
  logic [31:0] stat_stall_cnt;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          n, m, r, s, f, x;

  rq_t rq_q[$];
  rs_t rs_q[$];
  int  fl_q[$];
  cm_t cm_q[$];

  mc_port_mux_if #(.NUM_CORES(NC), .RTNCTL_WIDTH(RW)) bus();

  mc_port_mux #(
    .NUM_CORES(NC),
    .RTNCTL_WIDTH(RW)
  ) dut (
    .clk(clk),
    .i_reset(rst),
    .bus(bus.master),
    .stat_rq_cnt(stat_rq_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic unexp(string nm, logic [63:0] act);
    total++;
    $display("FAIL %s: got unexpected %0h want none (cycle %0d)",
             nm, act, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic rq_t mk_rq(int i, int c);
    rq_t e;
    e.cyc  = c;
    e.hdr  = {3'(i + 1), 4'(i + 4), 2'(i), 2'(i), 30'(32'h100 + i)};
    e.vadr = 48'hA000_0000 + 48'(i * 64);
    e.data = 64'hCAFE_0000_0000_0000 | 64'(i);
    return e;
  endfunction

  function automatic rs_t mk_rs(int c, logic [3:0] mk,
                                logic [29:0] rt, logic [63:0] d,
                                logic [6:0] cs);
    rs_t e;
    e.cyc = c; e.mask = mk; e.rtn = rt; e.data = d; e.cs = cs;
    return e;
  endfunction

  task automatic send_rs(logic [31:0] rt, logic [63:0] d,
                         logic [6:0] cs);
    bus.mc_rs_vld    = 1'b1;
    bus.mc_rs_rtnctl = rt;
    bus.mc_rs_data   = d;
    {bus.mc_rs_cmd, bus.mc_rs_scmd} = cs;
  endtask

  always @(negedge clk) begin
    if (bus.mc_rq_vld) begin
      if (rq_q.size() == 0) unexp("mc_rq", 64'(bus.mc_rq_rtnctl));
      else begin
        rq_t e;
        e = rq_q.pop_front();
        chk("rq_cyc", 64'(cyc), 64'(e.cyc));
        chk("rq_hdr", 64'({bus.mc_rq_cmd, bus.mc_rq_scmd,
                           bus.mc_rq_size, bus.mc_rq_rtnctl}),
            64'(e.hdr));
        chk("rq_vadr", 64'(bus.mc_rq_vadr), 64'(e.vadr));
        chk("rq_data", bus.mc_rq_data, e.data);
      end
    end
    if (bus.core_rs_vld != '0) begin
      if (rs_q.size() == 0) unexp("core_rs", 64'(bus.core_rs_vld));
      else begin
        rs_t e;
        e = rs_q.pop_front();
        chk("rs_cyc", 64'(cyc), 64'(e.cyc));
        chk("rs_vld", 64'(bus.core_rs_vld), 64'(e.mask));
        chk("rs_rtn", 64'(bus.core_rs_rtnctl), 64'(e.rtn));
        chk("rs_data", bus.core_rs_data, e.data);
        chk("rs_cs", 64'({bus.core_rs_cmd, bus.core_rs_scmd}),
            64'(e.cs));
      end
    end
    if (bus.mc_rq_flush) begin
      if (fl_q.size() == 0) unexp("mc_rq_flush", 64'(cyc));
      else chk("fl_cyc", 64'(cyc), 64'(fl_q.pop_front()));
    end
    if (bus.core_flush_cmplt != '0) begin
      if (cm_q.size() == 0)
        unexp("flush_cmplt", 64'(bus.core_flush_cmplt));
      else begin
        cm_t e;
        e = cm_q.pop_front();
        chk("cm_cyc", 64'(cyc), 64'(e.cyc));
        chk("cm_mask", 64'(bus.core_flush_cmplt), 64'(e.mask));
      end
    end
  end

  task automatic chk_idle(string nm);
    chk({nm, "_rq_vld"}, 64'(bus.mc_rq_vld), 64'd0);
    chk({nm, "_rs_vld"}, 64'(bus.core_rs_vld), 64'd0);
    chk({nm, "_rs_stall"}, 64'(bus.mc_rs_stall), 64'd0);
    chk({nm, "_flush"}, 64'(bus.mc_rq_flush), 64'd0);
    chk({nm, "_cmplt"}, 64'(bus.core_flush_cmplt), 64'd0);
    chk({nm, "_rtnctl"}, 64'(bus.mc_rq_rtnctl), 64'd0);
    chk({nm, "_stat_rq"}, 64'(stat_rq_cnt), 64'd0);
    chk({nm, "_stat_st"}, 64'(stat_stall_cnt), 64'd0);
  endtask

  initial begin
    bus.core_rq_vld = '0;
    bus.core_rq_flush = '0;
    bus.core_rs_stall = '0;
    bus.mc_rq_stall = 1'b0;
    bus.mc_rs_flush_cmplt = 1'b0;
    bus.mc_rs_vld = 1'b0;
    bus.mc_rs_cmd = '0;
    bus.mc_rs_scmd = '0;
    bus.mc_rs_data = '0;
    bus.mc_rs_rtnctl = '0;
    for (int i = 0; i < NC; i++) begin
      bus.core_rq_cmd[i*3 +: 3] = 3'(i + 1);
      bus.core_rq_scmd[i*4 +: 4] = 4'(i + 4);
      bus.core_rq_size[i*2 +: 2] = 2'(i);
      bus.core_rq_vadr[i*48 +: 48] = 48'hA000_0000 + 48'(i * 64);
      bus.core_rq_data[i*64 +: 64] =
        64'hCAFE_0000_0000_0000 | 64'(i);
      bus.core_rq_rtnctl[i*30 +: 30] = 30'(32'h100 + i);
    end
    tick();
    tick();
    rst = 1'b0;
    mid();
    chk_idle("reset");
    chk("reset_rdy", 64'(bus.core_rq_rdy), 64'd0);

    // two contenders alternate
    tick(); n = cyc;
    bus.core_rq_vld = 4'b0101;
    for (int k = 0; k < 4; k++) rq_q.push_back(mk_rq(2 * (k % 2), n + 1 + k));
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("alt_rdy", 64'(bus.core_rq_rdy), (k % 2 == 0) ? 64'h1 : 64'h4);
      tick();
    end
    bus.core_rq_vld = '0;
    tick();
    tick();

    // stalled port
    m = cyc;
    bus.mc_rq_stall = 1'b1;
    bus.core_rq_vld = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("stall_rdy", 64'(bus.core_rq_rdy), 64'd0);
      chk("stall_vld", 64'(bus.mc_rq_vld), 64'd0);
      tick();
    end
    bus.mc_rq_stall = 1'b0;
    rq_q.push_back(mk_rq(1, m + 6));
    mid();
    chk("unstall_rdy", 64'(bus.core_rq_rdy), 64'h2);
    tick();
    bus.core_rq_vld = '0;
    tick();
`ifdef MC_PORT_MUX_STATS_EN
    mid();
    chk("stat_rq", 64'(stat_rq_cnt), 64'd5);
    chk("stat_stall", 64'(stat_stall_cnt), 64'd5);
`endif

    // tag steering
    tick(); r = cyc;
    send_rs(32'hC000_0123, 64'h1122_3344_5566_7788, 7'h5A);
    rs_q.push_back(mk_rs(r + 1, 4'b1000, 30'h123,
                         64'h1122_3344_5566_7788, 7'h5A));
    tick();
    bus.mc_rs_vld = 1'b0;

    // response backpressure with two in flight
    tick(); s = cyc;
    bus.core_rs_stall = 4'b0010;
    mid();
    chk("rs_stall_lag", 64'(bus.mc_rs_stall), 64'd0);
    tick();
    send_rs({2'd1, 30'h0AA}, 64'hAAAA_0000_0000_0001, 7'h11);
    rs_q.push_back(mk_rs(s + 2, 4'b0010, 30'h0AA,
                         64'hAAAA_0000_0000_0001, 7'h11));
    mid();
    chk("rs_stall_on", 64'(bus.mc_rs_stall), 64'd1);
    tick();
    send_rs({2'd2, 30'h0BB}, 64'hBBBB_0000_0000_0002, 7'h22);
    rs_q.push_back(mk_rs(s + 3, 4'b0100, 30'h0BB,
                         64'hBBBB_0000_0000_0002, 7'h22));
    tick();
    bus.mc_rs_vld = 1'b0;
    bus.core_rs_stall = '0;
    tick();
    mid();
    chk("rs_stall_off", 64'(bus.mc_rs_stall), 64'd0);

    // merged flush, deferred late pulse
    tick(); f = cyc;
    bus.core_rq_flush = 4'b1001;
    fl_q.push_back(f + 2);
    tick();
    bus.core_rq_flush = '0;
    bus.core_rq_vld = 4'b0100;
    mid();
    chk("issue_block", 64'(bus.core_rq_rdy), 64'd0);
    tick();
    rq_q.push_back(mk_rq(2, f + 3));
    mid();
    chk("wait_grant", 64'(bus.core_rq_rdy), 64'h4);
    tick();
    bus.core_rq_vld = '0;
    tick();
    bus.core_rq_flush = 4'b0010;
    tick();
    bus.core_rq_flush = '0;
    tick();
    bus.mc_rs_flush_cmplt = 1'b1;
    cm_q.push_back('{f + 7, 4'b1001});
    fl_q.push_back(f + 9);
    tick();
    bus.mc_rs_flush_cmplt = 1'b0;
    repeat (4) tick();
    bus.mc_rs_flush_cmplt = 1'b1;
    cm_q.push_back('{f + 12, 4'b0010});
    tick();
    bus.mc_rs_flush_cmplt = 1'b0;
    tick();

    // reset while waiting on a flush
    tick(); x = cyc;
    bus.core_rq_flush = 4'b0100;
    fl_q.push_back(x + 2);
    tick();
    bus.core_rq_flush = '0;
    tick();
    bus.core_rs_stall = 4'b0001;
    tick();
    rst = 1'b1;
    mid();
    chk("pre_rst_stall", 64'(bus.mc_rs_stall), 64'd1);
    tick();
    rst = 1'b0;
    bus.core_rs_stall = '0;
    mid();
    chk_idle("midrst");
    tick();
    bus.mc_rs_flush_cmplt = 1'b1;
    send_rs({2'd3, 30'h077}, 64'h7777_0000_0000_0003, 7'h33);
    rs_q.push_back(mk_rs(x + 6, 4'b1000, 30'h077,
                         64'h7777_0000_0000_0003, 7'h33));
    bus.core_rq_vld = 4'b1010;
    rq_q.push_back(mk_rq(1, x + 6));
    rq_q.push_back(mk_rq(3, x + 7));
    mid();
    chk("rst_ptr_rdy", 64'(bus.core_rq_rdy), 64'h2);
    tick();
    bus.mc_rs_flush_cmplt = 1'b0;
    bus.mc_rs_vld = 1'b0;
    tick();
    bus.core_rq_vld = '0;
    repeat (4) tick();

    chk("rq_left", 64'(rq_q.size()), 64'd0);
    chk("rs_left", 64'(rs_q.size()), 64'd0);
    chk("fl_left", 64'(fl_q.size()), 64'd0);
    chk("cm_left", 64'(cm_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
